// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter with hold limit driving a shared data mux
module mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             s,
    output logic             gnt0,
    output logic             gnt1,
    output logic             valid,
    output logic [WIDTH-1:0] m
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_t;
    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);
    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       s_q, s_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    // next-state arbitration: tie goes to the requester not served last, holder preempted after MAX_HOLD cycles
    always_comb begin
        case (state_q)
            IDLE:    state_d = (req0 && req1) ? (last_q ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
            G0:      state_d = req0 ? ((req1 && cnt_q == CNT_MAX) ? G1 : G0) : req1 ? G1 : IDLE;
            G1:      state_d = req1 ? ((req0 && cnt_q == CNT_MAX) ? G0 : G1) : req0 ? G0 : IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d  = (state_d != state_q || state_q == IDLE) ? 4'd0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
        last_d = (state_d == G0 && state_q != G0) ? 1'b0 : (state_d == G1 && state_q != G1) ? 1'b1 : last_q;
        s_d    = (state_d == G0) ? 1'b0 : (state_d == G1) ? 1'b1 : s_q;
        gnt0_d = (state_d == G0);
        gnt1_d = (state_d == G1);
    end
    // state and registered outputs; reset drops any grant immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            s_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end
    assign s     = s_q;
    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign valid = gnt0_q | gnt1_q;
    assign m     = valid ? (s_q ? y : x) : '0;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and randomized checks of mux_arbiter against a behavioural model
module tb_mux_arbiter;
    localparam int MH = 4;
    logic       clock = 0, reset = 1, req0 = 0, req1 = 0;
    logic [7:0] x = 0, y = 0;
    logic       s, gnt0, gnt1, valid;
    logic [7:0] m;
    int         count = 0, fails = 0;
    int         mown = -1, mheld = 0, mlast = 1, ms = 0;

    mux_arbiter #(.WIDTH(8), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .x(x), .y(y), .s(s), .gnt0(gnt0), .gnt1(gnt1), .valid(valid), .m(m)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        mown = -1; mheld = 0; mlast = 1; ms = 0;
    endfunction

    // owner is -1 when nobody holds the output; mheld counts cycles owned so far
    function automatic void model_step(input logic r0, input logic r1);
        int nxt;
        logic own, oth;
        if (mown < 0) nxt = (r0 && r1) ? (mlast == 1 ? 0 : 1) : r0 ? 0 : r1 ? 1 : -1;
        else begin
            own = (mown == 0) ? r0 : r1;
            oth = (mown == 0) ? r1 : r0;
            if (own && !(oth && mheld >= MH)) nxt = mown;
            else if (oth) nxt = 1 - mown;
            else nxt = -1;
        end
        if (nxt >= 0 && nxt == mown) mheld++;
        else mheld = (nxt < 0) ? 0 : 1;
        if (nxt >= 0) begin
            if (nxt != mown) mlast = nxt;
            ms = nxt;
        end
        mown = nxt;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step(req0, req1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; req0 = 1; req1 = 1; x = 8'hFF; y = 8'hFF;
        model_reset();
        tick(); tick();
        count++;
        if ({gnt0, gnt1, valid, s, m} !== 12'h0) begin
            fails++;
            $display("FAIL reset_state: gnt0=%b gnt1=%b valid=%b s=%b m=%h, required all zero", gnt0, gnt1, valid, s, m);
        end
    endtask

    task automatic test_tie_first();
        @(negedge clock);
        reset = 0; req0 = 1; req1 = 1; x = 8'hA5; y = 8'h3C;
        tick();
        count++;
        if (gnt0 !== 1 || gnt1 !== 0 || s !== 0 || m !== 8'hA5) begin
            fails++;
            $display("FAIL tie_first: gnt0=%b gnt1=%b s=%b m=%h, required 1 0 0 a5", gnt0, gnt1, s, m);
        end
    endtask

    task automatic test_preempt();
        for (int i = 2; i <= MH; i++) begin
            tick();
            count++;
            if (gnt0 !== 1 || m !== 8'hA5) begin
                fails++;
                $display("FAIL preempt_hold0 cycle %0d: gnt0=%b m=%h, required 1 a5", i, gnt0, m);
            end
        end
        for (int i = 1; i <= MH; i++) begin
            tick();
            count++;
            if (gnt1 !== 1 || gnt0 !== 0 || s !== 1 || m !== 8'h3C) begin
                fails++;
                $display("FAIL preempt_hold1 cycle %0d: gnt0=%b gnt1=%b s=%b m=%h, required 0 1 1 3c", i, gnt0, gnt1, s, m);
            end
        end
        tick();
        count++;
        if (gnt0 !== 1 || gnt1 !== 0 || s !== 0) begin
            fails++;
            $display("FAIL preempt_back: gnt0=%b gnt1=%b s=%b, required 1 0 0", gnt0, gnt1, s);
        end
    endtask

    task automatic test_hold();
        req1 = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            count++;
            if (gnt0 !== 1 || valid !== 1) begin
                fails++;
                $display("FAIL hold cycle %0d: gnt0=%b valid=%b, required 1 1", i, gnt0, valid);
            end
        end
        req0 = 0;
        tick();
        count++;
        if (valid !== 0 || gnt0 !== 0 || m !== 8'h00 || s !== 0) begin
            fails++;
            $display("FAIL hold_release: valid=%b gnt0=%b m=%h s=%b, required 0 0 00 0", valid, gnt0, m, s);
        end
    endtask

    task automatic test_back_to_back();
        req1 = 1;
        tick();
        count++;
        if (gnt1 !== 1 || s !== 1) begin
            fails++;
            $display("FAIL b2b_enter_g1: gnt1=%b s=%b, required 1 1", gnt1, s);
        end
        req0 = 1; req1 = 0;
        tick();
        count++;
        if (gnt0 !== 1 || gnt1 !== 0 || valid !== 1) begin
            fails++;
            $display("FAIL b2b_handover: gnt0=%b gnt1=%b valid=%b, required 1 0 1", gnt0, gnt1, valid);
        end
    endtask

    task automatic test_async_reset();
        req0 = 0; req1 = 1;
        tick();
        count++;
        if (gnt1 !== 1) begin
            fails++;
            $display("FAIL areset_setup: gnt1=%b, required 1", gnt1);
        end
        #2 reset = 1;
        model_reset();
        #1;
        count++;
        if (gnt1 !== 0 || valid !== 0 || m !== 8'h00 || s !== 0) begin
            fails++;
            $display("FAIL areset_mid: gnt1=%b valid=%b m=%h s=%b, required 0 0 00 0", gnt1, valid, m, s);
        end
        @(negedge clock);
        reset = 0; req0 = 0; req1 = 1;
        tick();
        count++;
        if (gnt1 !== 1 || gnt0 !== 0 || s !== 1 || m !== y) begin
            fails++;
            $display("FAIL areset_regrant: gnt1=%b gnt0=%b s=%b m=%h, required 1 0 1 %h", gnt1, gnt0, s, m, y);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_m;
        for (int i = 0; i < 600; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            x = 8'($urandom); y = 8'($urandom);
            tick();
            exp_m = (mown < 0) ? 8'h00 : (mown == 1 ? y : x);
            count++;
            if (gnt0 !== (mown == 0) || gnt1 !== (mown == 1) || s !== ms[0] || valid !== (mown >= 0) || m !== exp_m) begin
                fails++;
                $display("FAIL random cycle %0d: gnt0=%b gnt1=%b s=%b valid=%b m=%h, required owner=%0d s=%0d m=%h", i, gnt0, gnt1, s, valid, m, mown, ms, exp_m);
            end
            count++;
            if ((gnt0 & gnt1) !== 0 || valid !== (gnt0 | gnt1) || (!valid && m !== 8'h00)) begin
                fails++;
                $display("FAIL invariant cycle %0d: gnt0=%b gnt1=%b valid=%b m=%h", i, gnt0, gnt1, valid, m);
            end
            if ($urandom_range(0, 5) == 0) begin
                x = 8'($urandom); y = 8'($urandom);
                #1;
                exp_m = (mown < 0) ? 8'h00 : (mown == 1 ? y : x);
                count++;
                if (m !== exp_m) begin
                    fails++;
                    $display("FAIL comb_follow cycle %0d: m=%h, required %h", i, m, exp_m);
                end
            end
            if ($urandom_range(0, 60) == 0) begin
                #1 reset = 1;
                model_reset();
                #1;
                count++;
                if (valid !== 0 || s !== 0 || m !== 8'h00) begin
                    fails++;
                    $display("FAIL random_reset cycle %0d: valid=%b s=%b m=%h, required 0 0 00", i, valid, s, m);
                end
                @(negedge clock);
                reset = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_first();
        test_preempt();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", count, fails);
        $finish;
    end
endmodule
